video_sync_gen: RTL and testbench
=================================

# video_sync_gen

Free-running raster timing generator: from the pixel clock it produces HSync, VSync, an active-video flag and pixel/line coordinates. It is the source end of the sync interface that the pattern generator and sync-to-count logic consume, and it replaces external sync inputs when the FPGA drives the display itself. Timing is fixed by parameters; the default is 640x480@60 with sync polarity matched to downstream rising-edge detection.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- SYNC_POL, 1: 1 = syncs active-high, 0 = active-low
- i_Clk  in  1  pixel clock; one clock only, all logic on its rising edge
- i_Rst_n  in  1  reset, asynchronous assert, active-low
- i_En  in  1  run enable; low holds the raster at origin
- o_HSync  out  1  horizontal sync
- o_VSync  out  1  vertical sync
- o_Active  out  1  high inside the visible region
- o_Col_Count  out  11  horizontal position, 0..H_TOTAL-1
- o_Row_Count  out  11  vertical position, 0..V_TOTAL-1
- o_Line_Start  out  1  one-cycle pulse at column 0
- o_Frame_Start  out  1  one-cycle pulse at (col 0, row 0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration error if any parameter is 0, or if H_TOTAL or V_TOTAL > 2047.
- Internal counters h and v, 11-bit unsigned. Each line is laid out as active, then front porch, then sync, then back porch. Lines within a frame follow the same order.
- h increments every enabled cycle. At h = H_TOTAL-1, h wraps to 0 and v increments. At v = V_TOTAL-1 with h = H_TOTAL-1, both wrap to 0.
- The wrap compare is exact equality. Counters never reach H_TOTAL or V_TOTAL.
- hsync_raw = (h >= H_ACTIVE+H_FP) and (h < H_ACTIVE+H_FP+H_SYNC). vsync_raw uses the same rule on v.
- VSync changes on the cycle h wraps to 0, so it is line-aligned.
- o_HSync = hsync_raw when SYNC_POL = 1, otherwise its inverse. o_VSync follows the same rule.
- o_Active = (h < H_ACTIVE) and (v < V_ACTIVE).
- o_Line_Start = (h == 0). o_Frame_Start = (h == 0) and (v == 0).
- i_En low: h and v are forced to 0. Outputs show the origin state, except o_Line_Start and o_Frame_Start, which are gated low.
- i_En high: counting resumes from (0,0).
- i_En dropping mid-frame: the frame is abandoned. No partial-frame completion.

## Timing
- All outputs are registered, one cycle behind the internal counters. Every output in a given cycle describes the same (col, row), so the relationship between them is exact.
- Reset values, held while i_Rst_n is low:
  - o_Col_Count = 0, o_Row_Count = 0
  - o_Active = 0, o_Line_Start = 0, o_Frame_Start = 0
  - o_HSync and o_VSync at their inactive level (0 when SYNC_POL = 1)
- Reset release: h and v are at 0. The first enabled rising edge registers (0,0) onto the outputs with o_Frame_Start = 1 and o_Active = 1.
- Reset asserted mid-frame takes effect asynchronously, with no pending pulses. Reset has priority over i_En.
- HSync period is exactly H_TOTAL cycles. VSync period is exactly H_TOTAL*V_TOTAL cycles. Sync widths are H_SYNC cycles and V_SYNC*H_TOTAL cycles.
- o_Frame_Start and o_Line_Start are single-cycle; they coincide on frame start.
- With SYNC_POL = 1, a sync-to-count consumer sees its sync rising edge at h = H_ACTIVE+H_FP.

## Structure
- Package video_timing_pkg holds:
  - COUNT_W = 11
  - default VGA 640x480 timing constants
  - a function returning the total from active, FP, SYNC and BP
- One sub-module, timing_axis, instantiated twice, once for H and once for V.
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Inputs: step enable, clear.
  - Outputs: count, wrap, in_active, in_sync.
  - The H instance steps every enabled cycle. The V instance steps on the H instance's wrap.
- The top level holds the enable and clear logic, the polarity mux and the output registers.

## Test plan
- Small timing (H 8/2/3/1, total 14; V 4/1/2/1, total 8; SYNC_POL = 1), i_En = 1 after reset:
  - o_HSync high for exactly 3 cycles with col = 10..12, period 14 cycles
  - o_VSync high for 28 cycles with row = 5..6, period 112 cycles
- Same config, 3 frames: o_Active high 32 cycles per frame, only at col < 8 and row < 4. o_Frame_Start spaced exactly 112 cycles apart.
- Wrap: at col 13, row 7, the next cycle shows col 0, row 0 with o_Frame_Start = o_Line_Start = 1.
- SYNC_POL = 0: the sync waveforms are the exact inverse of the first scenario. Reset level is 1.
- i_En dropped at col 5, row 2 for 4 cycles:
  - outputs show (0,0), pulses stay 0
  - on re-enable, the first enabled cycle gives col 0, row 0 with o_Frame_Start = 1
- i_Rst_n pulsed low mid-sync (between clock edges): outputs reach their reset values immediately. After release, the first clock edge gives (0,0).

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared counter width, default VGA timing and axis total helper
package video_timing_pkg;
    localparam int COUNT_W      = 11;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one raster axis counter laid out as active, front porch, sync, back porch
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Step,
    input  logic               i_Clr,
    output logic [COUNT_W-1:0] o_Count,
    output logic               o_Wrap,
    output logic               o_In_Active,
    output logic               o_In_Sync
);
    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 || TOTAL > 2047) begin : g_bad_timing
        $error("timing_axis: zero-length segment or total exceeds 2047");
    end

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            r_count <= '0;
        else if (i_Clr)
            r_count <= '0;
        else if (i_Step)
            r_count <= o_Wrap ? '0 : r_count + 1'b1;
    end

    assign o_Count     = r_count;
    assign o_Wrap      = r_count == COUNT_W'(TOTAL - 1);
    assign o_In_Active = r_count < COUNT_W'(ACTIVE);
    assign o_In_Sync   = (r_count >= COUNT_W'(SYNC_START)) && (r_count < COUNT_W'(SYNC_END));
endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen: free-running raster timing generator with registered sync, active and coordinates
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_POL = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_En,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic        o_Active,
    output logic [10:0] o_Col_Count,
    output logic [10:0] o_Row_Count,
    output logic        o_Line_Start,
    output logic        o_Frame_Start
);
    localparam logic SYNC_INV = (SYNC_POL == 0);

    logic [COUNT_W-1:0] w_h, w_v;
    logic w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_h_sync, w_v_sync;
    logic r_hsync, r_vsync, r_active, r_line, r_frame;
    logic [COUNT_W-1:0] r_col, r_row;

    timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Step(i_En), .i_Clr(~i_En),
        .o_Count(w_h), .o_Wrap(w_h_wrap), .o_In_Active(w_h_act), .o_In_Sync(w_h_sync)
    );

    timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Step(i_En & w_h_wrap), .i_Clr(~i_En),
        .o_Count(w_v), .o_Wrap(w_v_wrap), .o_In_Active(w_v_act), .o_In_Sync(w_v_sync)
    );

    // While disabled the outputs present the origin: visible, syncs idle, no pulses
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
            r_line   <= 1'b0;
            r_frame  <= 1'b0;
            r_hsync  <= SYNC_INV;
            r_vsync  <= SYNC_INV;
        end else begin
            r_col    <= i_En ? w_h : '0;
            r_row    <= i_En ? w_v : '0;
            r_active <= ~i_En | (w_h_act & w_v_act);
            r_line   <= i_En & (w_h == '0);
            r_frame  <= i_En & (w_h == '0) & (w_v == '0);
            r_hsync  <= (i_En & w_h_sync) ^ SYNC_INV;
            r_vsync  <= (i_En & w_v_sync) ^ SYNC_INV;
        end
    end

    assign o_HSync       = r_hsync;
    assign o_VSync       = r_vsync;
    assign o_Active      = r_active;
    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Line_Start  = r_line;
    assign o_Frame_Start = r_frame;
endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: scoreboard bench on a 14x8 raster, both sync polarities side by side
module tb_video_sync_gen;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    always #5 clk = ~clk;

    logic        p_hs, p_vs, p_act, p_ls, p_fs, n_hs, n_vs, n_act, n_ls, n_fs;
    logic [10:0] p_col, p_row, n_col, n_row;

    video_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .o_HSync(p_hs), .o_VSync(p_vs),
        .o_Active(p_act), .o_Col_Count(p_col), .o_Row_Count(p_row),
        .o_Line_Start(p_ls), .o_Frame_Start(p_fs)
    );

    video_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)) dut_neg (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .o_HSync(n_hs), .o_VSync(n_vs),
        .o_Active(n_act), .o_Col_Count(n_col), .o_Row_Count(n_row),
        .o_Line_Start(n_ls), .o_Frame_Start(n_fs)
    );

    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic hs, vs, act, ls, fs;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int checks = 0, failures = 0;
    int mh = 0, mv = 0;
    logic tally_on = 1'b0;
    int hs_high = 0, vs_high = 0, act_high = 0, fs_cnt = 0, cyc = 0;
    int last_fs = -1, last_hs_rise = -1, last_vs_rise = -1;
    logic prev_hs = 1'b0, prev_vs = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic step(input logic e);
        exp_t x;
        @(negedge clk);
        en = e;
        if (!e) begin
            x.col = 0; x.row = 0; x.hs = 0; x.vs = 0; x.act = 1; x.ls = 0; x.fs = 0;
            mh = 0; mv = 0;
        end else begin
            x.col = 11'(mh);
            x.row = 11'(mv);
            x.hs  = (mh >= 10) && (mh < 13);
            x.vs  = (mv >= 5) && (mv < 7);
            x.act = (mh < 8) && (mv < 4);
            x.ls  = (mh == 0);
            x.fs  = (mh == 0) && (mv == 0);
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else mh++;
        end
        q.push_back(x);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_col"}, int'(p_col), 0);
        chk({tag, "_row"}, int'(p_row), 0);
        chk({tag, "_active"}, int'(p_act), 0);
        chk({tag, "_line"}, int'(p_ls), 0);
        chk({tag, "_frame"}, int'(p_fs), 0);
        chk({tag, "_hsync"}, int'(p_hs), 0);
        chk({tag, "_vsync"}, int'(p_vs), 0);
        chk({tag, "_hsync_neg"}, int'(n_hs), 1);
        chk({tag, "_vsync_neg"}, int'(n_vs), 1);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("col", int'(p_col), int'(m_e.col));
            chk("row", int'(p_row), int'(m_e.row));
            chk("hsync", int'(p_hs), int'(m_e.hs));
            chk("vsync", int'(p_vs), int'(m_e.vs));
            chk("active", int'(p_act), int'(m_e.act));
            chk("line_start", int'(p_ls), int'(m_e.ls));
            chk("frame_start", int'(p_fs), int'(m_e.fs));
            chk("hsync_neg", int'(n_hs), int'(!m_e.hs));
            chk("vsync_neg", int'(n_vs), int'(!m_e.vs));
            if (tally_on) begin
                hs_high  += int'(p_hs);
                vs_high  += int'(p_vs);
                act_high += int'(p_act);
                if (p_fs) begin
                    if (last_fs >= 0) chk("frame_period", cyc - last_fs, 112);
                    last_fs = cyc;
                    fs_cnt++;
                end
                if (p_hs && !prev_hs) begin
                    if (last_hs_rise >= 0) chk("hsync_period", cyc - last_hs_rise, 14);
                    last_hs_rise = cyc;
                end
                if (p_vs && !prev_vs) begin
                    if (last_vs_rise >= 0) chk("vsync_period", cyc - last_vs_rise, 112);
                    last_vs_rise = cyc;
                end
                prev_hs = p_hs;
                prev_vs = p_vs;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_chk("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tally_on = 1'b1;
        repeat (336) step(1'b1);
        @(posedge clk);
        #2;
        tally_on = 1'b0;
        chk("hsync_high_3frames", hs_high, 72);
        chk("vsync_high_3frames", vs_high, 84);
        chk("active_high_3frames", act_high, 96);
        chk("frame_start_count", fs_cnt, 3);
        repeat (34) step(1'b1);
        repeat (4) step(1'b0);
        step(1'b1);
        repeat (11) step(1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        rst_chk("rst_async");
        mh = 0;
        mv = 0;
        @(posedge clk);
        #2;
        rst_chk("rst_held");
        #2;
        rst_n = 1'b1;
        repeat (21) step(1'b1);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
